// File: rtl/lbuf_writer_pkg.sv
// Shared line-buffer constants for the capture writer and the output timing
// generator: buffer geometry, the {line, x} write-address packing, and the
// lock-state encoding.
package lbuf_writer_pkg;

    localparam int LBUF_LINES = 40;
    localparam int LBUF_XW    = 9;
    localparam int LBUF_YW    = 6;
    localparam int LBUF_AW    = LBUF_YW + LBUF_XW;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        MEASURE  = 2'd1,
        CONFIRM  = 2'd2,
        LOCKED   = 2'd3
    } lock_state_t;

    function automatic logic [LBUF_AW-1:0] lbuf_pack_addr(input logic [LBUF_YW-1:0] line,
                                                          input logic [LBUF_XW-1:0] x);
        return {line, x};
    endfunction

    function automatic logic [LBUF_YW-1:0] lbuf_addr_line(input logic [LBUF_AW-1:0] addr);
        return addr[LBUF_AW-1:LBUF_XW];
    endfunction

    function automatic logic [LBUF_XW-1:0] lbuf_addr_x(input logic [LBUF_AW-1:0] addr);
        return addr[LBUF_XW-1:0];
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Falling-edge detector for the negative-polarity source syncs.
// Ports:
//   PCLK, reset_n        source pixel clock, async active-low reset
//   HSYNC_in, VSYNC_in   raw source syncs
//   hs_fall, vs_fall     high in the cycle a sync input is first seen low
// The previous-value registers run every PCLK regardless of pix_en and reset
// high so that a sync already low at reset release reads as an edge.
module sync_edge_det (
    input  logic PCLK,
    input  logic reset_n,
    input  logic HSYNC_in,
    input  logic VSYNC_in,
    output logic hs_fall,
    output logic vs_fall
);

    logic prev_hs;
    logic prev_vs;

    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) begin
            prev_hs <= 1'b1;
            prev_vs <= 1'b1;
        end else begin
            prev_hs <= HSYNC_in;
            prev_vs <= VSYNC_in;
        end
    end

    assign hs_fall = prev_hs & ~HSYNC_in;
    assign vs_fall = prev_vs & ~VSYNC_in;

endmodule

// File: rtl/lbuf_writer.sv
// Capture-side line-buffer writer. Tracks source H/V position in pix_en ticks,
// qualifies source timing, and writes active pixels into a circular buffer of
// NUM_LINES lines.
// Ports:
//   PCLK, reset_n         source pixel clock, async active-low reset
//   pix_en                pixel-valid qualifier
//   HSYNC_in, VSYNC_in    negative-polarity source syncs
//   pix_in                source pixel
//   wr_en/wr_addr/wr_data buffer write port, address {line, x}
//   locked                source timing qualified
//   frame_start           one-cycle pulse per frame start
//   h_total, v_total      length of last complete line / frame
//
// state    | meaning
// UNLOCKED | no timing reference; waiting for a frame start
// MEASURE  | learning line length and frame height
// CONFIRM  | checking one more frame against the learned height
// LOCKED   | timing qualified; active pixels are written
module lbuf_writer
    import lbuf_writer_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int X_OFFSET  = 64,
    parameter int H_ACTIVE  = 384,
    parameter int Y_OFFSET  = 16,
    parameter int V_ACTIVE  = 224,
    parameter int NUM_LINES = LBUF_LINES,
    parameter int H_TOL     = 2
) (
    input  logic               PCLK,
    input  logic               reset_n,
    input  logic               pix_en,
    input  logic               HSYNC_in,
    input  logic               VSYNC_in,
    input  logic [DATA_W-1:0]  pix_in,
    output logic               wr_en,
    output logic [LBUF_AW-1:0] wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               locked,
    output logic               frame_start,
    output logic [11:0]        h_total,
    output logic [10:0]        v_total
);

    localparam logic [11:0]        HPOS_MAX  = 12'hFFF;
    localparam logic [10:0]        VPOS_MAX  = 11'h7FF;
    localparam logic [11:0]        X_LO      = 12'(X_OFFSET);
    localparam logic [11:0]        X_HI      = 12'(X_OFFSET + H_ACTIVE);
    localparam logic [10:0]        Y_LO      = 11'(Y_OFFSET);
    localparam logic [10:0]        Y_HI      = 11'(Y_OFFSET + V_ACTIVE);
    localparam logic [LBUF_YW-1:0] LIDX_LAST = LBUF_YW'(NUM_LINES - 1);
    localparam logic [11:0]        TOL       = 12'(H_TOL);

    logic               hs_fall;
    logic               vs_fall;
    logic [11:0]        hpos;
    logic [10:0]        vpos;
    logic [10:0]        vpos_nxt;
    logic [LBUF_YW-1:0] lidx;
    logic               vs_pend;
    lock_state_t        state;
    lock_state_t        state_nxt;
    logic [11:0]        h_ref;
    logic [10:0]        v_ref;
    logic               ref_valid;
    logic               bad;

    logic               fs_cond;
    logic               in_col;
    logic               in_row;
    logic               wr_cond;
    logic [10:0]        v_meas;
    logic [11:0]        h_diff;
    logic               h_dev;
    logic               bad_eff;

    sync_edge_det u_sync_edge_det (
        .PCLK     (PCLK),
        .reset_n  (reset_n),
        .HSYNC_in (HSYNC_in),
        .VSYNC_in (VSYNC_in),
        .hs_fall  (hs_fall),
        .vs_fall  (vs_fall)
    );

    // A VS edge only arms the frame start; the HS edge that follows fires it.
    // A pending flag set in the same cycle as an HS edge is not yet visible.
    assign fs_cond = hs_fall & vs_pend;
    assign in_col  = (hpos >= X_LO) && (hpos < X_HI);
    assign in_row  = (vpos >= Y_LO) && (vpos < Y_HI);
    assign wr_cond = locked & pix_en & ~hs_fall & in_col & in_row;
    assign v_meas  = vpos + 11'd1;

    // Line-length deviation of the line ending on this HS edge, against the
    // first line of the current frame.
    assign h_diff  = (hpos >= h_ref) ? (hpos - h_ref) : (h_ref - hpos);
    assign h_dev   = ref_valid && (h_diff > TOL);
    assign bad_eff = bad | (hs_fall & h_dev);

    always_comb begin
        vpos_nxt = vpos;
        if (fs_cond) begin
            vpos_nxt = '0;
        end else if (hs_fall && (vpos != VPOS_MAX)) begin
            vpos_nxt = vpos + 11'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (fs_cond) begin
            unique case (state)
                UNLOCKED: state_nxt = MEASURE;
                MEASURE:  if (!bad_eff && (v_meas > Y_HI)) state_nxt = CONFIRM;
                CONFIRM:  state_nxt = (!bad_eff && (v_meas == v_ref)) ? LOCKED : MEASURE;
                LOCKED:   if (bad_eff || (v_meas != v_ref)) state_nxt = UNLOCKED;
                default:  state_nxt = UNLOCKED;
            endcase
        end else if ((state == LOCKED) && (vpos_nxt == VPOS_MAX)) begin
            // VSYNC lost: vertical counter ran out without a frame start.
            state_nxt = UNLOCKED;
        end
    end

    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) begin
            state       <= UNLOCKED;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            h_total     <= '0;
            v_total     <= '0;
            hpos        <= '0;
            vpos        <= '0;
            lidx        <= '0;
            vs_pend     <= 1'b0;
            h_ref       <= '0;
            v_ref       <= '0;
            ref_valid   <= 1'b0;
            bad         <= 1'b0;
        end else begin
            state       <= state_nxt;
            locked      <= (state_nxt == LOCKED);
            frame_start <= fs_cond;
            wr_en       <= wr_cond;
            vpos        <= vpos_nxt;

            if (wr_cond) begin
                wr_data <= pix_in;
                wr_addr <= lbuf_pack_addr(lidx, LBUF_XW'(hpos - X_LO));
            end

            if (vs_fall) begin
                vs_pend <= 1'b1;
            end else if (fs_cond) begin
                vs_pend <= 1'b0;
            end

            if (hs_fall) begin
                h_total <= hpos;
                hpos    <= '0;
            end else if (pix_en && (hpos != HPOS_MAX)) begin
                hpos <= hpos + 12'd1;
            end

            if (fs_cond) begin
                v_total <= v_meas;
                lidx    <= '0;
            end else if (hs_fall && in_row) begin
                lidx <= (lidx == LIDX_LAST) ? '0 : lidx + LBUF_YW'(1);
            end

            if (fs_cond) begin
                ref_valid <= 1'b0;
                bad       <= 1'b0;
                if ((state == MEASURE) && (state_nxt == CONFIRM)) begin
                    v_ref <= v_meas;
                end
            end else if (hs_fall) begin
                if (!ref_valid) begin
                    h_ref     <= hpos;
                    ref_valid <= 1'b1;
                end else if (h_dev) begin
                    bad <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lbuf_writer.sv
// Scoreboard bench for lbuf_writer using a reduced geometry (16-tick lines,
// 12-line frames, 4-line buffer) so that every scenario, including a
// 2047-line VSYNC loss, fits a short run.
module tb_lbuf_writer;

    localparam int DW  = 12;
    localparam int XO  = 4;
    localparam int HA  = 8;
    localparam int YO  = 2;
    localparam int VA  = 6;
    localparam int NL  = 4;
    localparam int LEN = 16;

    logic          PCLK     = 1'b0;
    logic          reset_n  = 1'b0;
    logic          pix_en   = 1'b0;
    logic          HSYNC_in = 1'b1;
    logic          VSYNC_in = 1'b1;
    logic [DW-1:0] pix_in   = '0;
    logic          wr_en;
    logic [14:0]   wr_addr;
    logic [DW-1:0] wr_data;
    logic          locked;
    logic          frame_start;
    logic [11:0]   h_total;
    logic [10:0]   v_total;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_wr     = 0;

    typedef struct {
        int            t;
        logic [14:0]   addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    typedef struct {
        int          t;
        logic        lk;
        logic [10:0] vt;
        logic [11:0] ht;
    } fs_exp_t;

    wr_exp_t wq[$];
    fs_exp_t fq[$];

    // Source model state: line index since the last frame start, buffer line,
    // length of the most recent line, and the lock level expected this frame.
    int v      = 0;
    int lidx   = 0;
    int last_h = 0;
    bit fs_pend    = 1'b0;
    bit exp_wr     = 1'b0;
    bit frame_lock = 1'b0;

    lbuf_writer #(
        .DATA_W    (DW),
        .X_OFFSET  (XO),
        .H_ACTIVE  (HA),
        .Y_OFFSET  (YO),
        .V_ACTIVE  (VA),
        .NUM_LINES (NL),
        .H_TOL     (2)
    ) dut (
        .PCLK        (PCLK),
        .reset_n     (reset_n),
        .pix_en      (pix_en),
        .HSYNC_in    (HSYNC_in),
        .VSYNC_in    (VSYNC_in),
        .pix_in      (pix_in),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .locked      (locked),
        .frame_start (frame_start),
        .h_total     (h_total),
        .v_total     (v_total)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_locked", locked, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_h_total", h_total, 0);
        check("rst_v_total", v_total, 0);
    endtask

    // Monitor: pops and compares whenever the DUT presents a write or a frame start.
    always @(negedge PCLK) begin
        wr_exp_t we;
        fs_exp_t fe;
        if (wr_en) begin
            n_wr++;
            if (wq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h at cycle %0d, expected no write",
                         wr_addr, wr_data, cyc);
            end else begin
                we = wq.pop_front();
                check("wr_cycle", cyc, we.t);
                check("wr_addr", wr_addr, we.addr);
                check("wr_data", wr_data, we.data);
            end
        end
        if (frame_start) begin
            if (fq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_frame_start: got pulse at cycle %0d, expected none", cyc);
            end else begin
                fe = fq.pop_front();
                check("fs_cycle", cyc, fe.t);
                check("fs_locked", locked, fe.lk);
                check("fs_v_total", v_total, fe.vt);
                check("fs_h_total", h_total, fe.ht);
            end
        end
    end

    // One source line of len pix_en ticks. half: pix_en on odd cycles only.
    // vs_mode 1: VSYNC pulse mid-line; 2: VSYNC falls with HSYNC at cycle 0.
    // rst_at >= 0: assert reset at that cycle of the line and abandon it.
    task automatic run_line(input int len, input bit half, input int vs_mode, input int rst_at);
        int            ncyc;
        int            k;
        logic [DW-1:0] px;
        ncyc = half ? 2 * len : len;
        if (fs_pend) begin
            fq.push_back('{cyc + 1, frame_lock, 11'(v + 1), 12'(last_h)});
            v       = 0;
            lidx    = 0;
            fs_pend = 1'b0;
            exp_wr  = frame_lock;
        end else begin
            if (v >= YO && v < YO + VA) lidx = (lidx + 1) % NL;
            if (v < 2047) v++;
            if (v == 2047) exp_wr = 1'b0;
        end
        for (int c = 0; c < ncyc; c++) begin
            HSYNC_in = (c >= (half ? 4 : 2));
            VSYNC_in = !((vs_mode == 1 && c >= 5 && c < 8) || (vs_mode == 2 && c < 3));
            pix_en   = half ? (c % 2 == 1) : 1'b1;
            px       = DW'($urandom);
            pix_in   = px;
            if (c > 0 && pix_en) begin
                k = half ? (c - 1) / 2 : c - 1;
                if (exp_wr && v >= YO && v < YO + VA && k >= XO && k < XO + HA)
                    wq.push_back('{cyc + 1, {6'(lidx), 9'(k - XO)}, px});
            end
            if (c == rst_at) begin
                reset_n = 1'b0;
                #1;
                check_reset_outputs();
                wq.delete();
                fq.delete();
                HSYNC_in = 1'b1;
                VSYNC_in = 1'b1;
                pix_en   = 1'b0;
                v        = 0;
                lidx     = 0;
                fs_pend  = 1'b0;
                exp_wr   = 1'b0;
                repeat (3) @(posedge PCLK);
                #1;
                reset_n = 1'b1;
                return;
            end
            @(posedge PCLK);
            #1;
            if (c == 0 && (v == 2046 || v == 2047))
                check("locked_vs_loss", locked, (v == 2046));
        end
        last_h = half ? len : len - 1;
        if (vs_mode != 0) fs_pend = 1'b1;
    endtask

    task automatic frame(input int nlines, input bit lk, input bit half, input int short_at,
                         input int vs_mode, input int rst_line);
        frame_lock = lk;
        for (int i = 0; i < nlines; i++) begin
            run_line((i == short_at) ? 10 : LEN, half, (i == nlines - 1) ? vs_mode : 0,
                     (i == rst_line) ? 8 : -1);
            if (i == rst_line) break;
        end
    endtask

    initial begin
        int w0;
        repeat (2) @(posedge PCLK);
        #1;
        check_reset_outputs();
        reset_n = 1'b1;

        // Acquisition: lock rises at the third frame start.
        run_line(LEN, 0, 1, -1);
        frame(12, 0, 0, -1, 1, -1);
        frame(12, 0, 0, -1, 1, -1);
        frame(12, 1, 0, -1, 1, -1);

        w0 = n_wr;
        frame(12, 1, 0, -1, 1, -1);
        check("writes_nominal_frame", n_wr - w0, VA * HA);

        w0 = n_wr;
        frame(12, 1, 1, -1, 1, -1);
        check("writes_half_duty_frame", n_wr - w0, VA * HA);

        // Short line at active row 4: 5 pixels written there, lock lost next frame.
        w0 = n_wr;
        frame(12, 1, 0, 4, 1, -1);
        check("writes_short_line_frame", n_wr - w0, (VA - 1) * HA + 5);

        w0 = n_wr;
        frame(12, 0, 0, -1, 1, -1);
        check("writes_after_unlock", n_wr - w0, 0);
        frame(12, 0, 0, -1, 1, -1);
        frame(12, 0, 0, -1, 1, -1);
        frame(12, 1, 0, -1, 1, -1);

        // Coincident VS/HS edge on the last line, then reset mid active row 3.
        frame(12, 1, 0, -1, 2, -1);
        frame(12, 1, 0, -1, 1, 3);

        w0 = n_wr;
        run_line(LEN, 0, 1, -1);
        frame(12, 0, 0, -1, 1, -1);
        frame(12, 0, 0, -1, 1, -1);
        check("writes_before_relock", n_wr - w0, 0);
        frame(12, 1, 0, -1, 1, -1);

        // VSYNC removed while locked.
        frame(2052, 1, 0, -1, 0, -1);

        HSYNC_in = 1'b1;
        pix_en   = 1'b0;
        repeat (4) @(posedge PCLK);
        #1;
        check("locked_end", locked, 0);
        check("write_queue_empty", wq.size(), 0);
        check("fs_queue_empty", fq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
